// File: rtl/upc_monitor.sv
// Posedge checker for a negedge-updated 3-bit up/down counter: verifies +/-1 steps mod 8,
// pulses on wraps and counts step errors. Optional extended position under UPC_MON_POS_EN.
module upc_monitor #(
    parameter int ERR_W  = 4,
    parameter int WRAP_W = 8
`ifdef UPC_MON_POS_EN
    ,
    parameter int POS_W  = 12
`endif
) (
    input  logic              clk,
    input  logic              preclr,
    input  logic              up_down,
    input  logic [2:0]        q,
    input  logic              clr_err,
    output logic              tc_up,
    output logic              tc_dn,
    output logic              cnt_err,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              mon_valid
`ifdef UPC_MON_POS_EN
    ,
    output logic [POS_W-1:0]  pos
`endif
);

    // state | meaning
    // SYNC  | first sample after preclr; q must be 0, no step check
    // TRACK | counter verified, checking every step
    // FAULT | error latched; still checking, clr_err on a good step returns to TRACK
    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] prev_q;
    logic       prev_ud;
    logic [2:0] expected;
    logic       step_ok;
    logic       set_err;
    logic       clr_sticky;
    logic       err_inc;
    logic       wrap_up;
    logic       wrap_dn;
    logic       pos_step;

    assign expected = prev_q + (prev_ud ? 3'd1 : 3'd7);
    assign step_ok  = (q == expected);

    always_comb begin
        state_d    = state_q;
        set_err    = 1'b0;
        clr_sticky = 1'b0;
        err_inc    = 1'b0;
        wrap_up    = 1'b0;
        wrap_dn    = 1'b0;
        pos_step   = 1'b0;
        case (state_q)
            SYNC: begin
                if (q != 3'd0) begin
                    set_err = 1'b1;
                    err_inc = 1'b1;
                    state_d = FAULT;
                end else begin
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (step_ok) begin
                    wrap_up  = prev_ud  && (prev_q == 3'd7) && (q == 3'd0);
                    wrap_dn  = !prev_ud && (prev_q == 3'd0) && (q == 3'd7);
                    pos_step = 1'b1;
                end else begin
                    set_err = 1'b1;
                    err_inc = 1'b1;
                    state_d = FAULT;
                end
            end
            FAULT: begin
                if (!step_ok) begin
                    err_inc = 1'b1;
                end else begin
                    wrap_up = prev_ud  && (prev_q == 3'd7) && (q == 3'd0);
                    wrap_dn = !prev_ud && (prev_q == 3'd0) && (q == 3'd7);
                    if (clr_err) begin
                        clr_sticky = 1'b1;
                        state_d    = TRACK;
                    end
                end
            end
            default: state_d = SYNC;
        endcase
    end

    always_ff @(posedge clk or posedge preclr) begin
        if (preclr) begin
            state_q   <= SYNC;
            prev_q    <= 3'd0;
            prev_ud   <= 1'b0;
            tc_up     <= 1'b0;
            tc_dn     <= 1'b0;
            cnt_err   <= 1'b0;
            err_cnt   <= '0;
            wrap_cnt  <= '0;
            mon_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= q;
            prev_ud   <= up_down;
            tc_up     <= wrap_up;
            tc_dn     <= wrap_dn;
            mon_valid <= 1'b1;
            if (set_err) begin
                cnt_err <= 1'b1;
            end else if (clr_sticky) begin
                cnt_err <= 1'b0;
            end
            if (err_inc && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
            if (wrap_up || wrap_dn) begin
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end
        end
    end

`ifdef UPC_MON_POS_EN
    // Position only follows steps verified while tracking; wraps two's-complement.
    always_ff @(posedge clk or posedge preclr) begin
        if (preclr) begin
            pos <= '0;
        end else if (pos_step) begin
            pos <= prev_ud ? pos + POS_W'(1) : pos - POS_W'(1);
        end
    end
`else
    logic unused_pos_step;
    assign unused_pos_step = pos_step;
`endif

endmodule
